// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - two-requester round-robin write arbiter with register-file zero-fill
//
// Purpose: arbitrates two write requesters onto a single registered
// register-file write port. It can also sweep the whole register file with
// zeros on request.
//
// Optional feature macro: WR_FWD_EN adds the write-forwarding lookup ports.
//
// Ports:
//   clock                  rising-edge clock
//   reset                  asynchronous active-high reset
//   req0/req1              write requests
//   addr0/addr1            target register per requester
//   data0/data1            write data per requester
//   gnt0/gnt1              combinational grants (handshake = reqN & gntN)
//   clr_start              one-cycle pulse that starts a zero-fill
//   busy                   high while the zero-fill runs
//   clr_done               one-cycle pulse alongside the last clear write
//   enc/addrc/datac        registered register-file write port
//   fwd_addr (WR_FWD_EN)   lookup address
//   fwd_hit  (WR_FWD_EN)   in-flight write targets fwd_addr
//   fwd_data (WR_FWD_EN)   in-flight write data on hit, else 0
module regfile_wr_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] data0,
   input  logic [DATA_W-1:0] data1,
   output logic              gnt0,
   output logic              gnt1,
   input  logic              clr_start,
   output logic              busy,
   output logic              clr_done,
   output logic              enc,
   output logic [ADDR_W-1:0] addrc,
   output logic [DATA_W-1:0] datac
`ifdef WR_FWD_EN
   ,
   input  logic [ADDR_W-1:0] fwd_addr,
   output logic              fwd_hit,
   output logic [DATA_W-1:0] fwd_data
`endif
);

   typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_t            r_state;
   logic              r_ptr;     // 0: requester 0 wins a tie, 1: requester 1 wins
   logic [ADDR_W-1:0] r_cnt;
   logic              r_enc;
   logic [ADDR_W-1:0] r_addrc;
   logic [DATA_W-1:0] r_datac;
   logic              r_busy;
   logic              r_done;

   logic              w_arb_en;
   logic              w_gnt0;
   logic              w_gnt1;

   // Grants are suppressed during reset, during a clear, and on the cycle a
   // clear is launched, so a clear always wins over pending requests.
   assign w_arb_en = !reset && (r_state == S_IDLE) && !clr_start;
   assign w_gnt0   = w_arb_en && req0 && (!req1 || !r_ptr);
   assign w_gnt1   = w_arb_en && req1 && (!req0 ||  r_ptr);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_ptr   <= 1'b0;
         r_cnt   <= '0;
         r_enc   <= 1'b0;
         r_addrc <= '0;
         r_datac <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_enc  <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (clr_start) begin
                  r_state <= S_CLEAR;
                  r_busy  <= 1'b1;
               end else if (w_gnt0) begin
                  r_enc   <= 1'b1;
                  r_addrc <= addr0;
                  r_datac <= data0;
                  r_ptr   <= 1'b1;
               end else if (w_gnt1) begin
                  r_enc   <= 1'b1;
                  r_addrc <= addr1;
                  r_datac <= data1;
                  r_ptr   <= 1'b0;
               end
            end
            S_CLEAR: begin
               r_enc   <= 1'b1;
               r_addrc <= r_cnt;
               r_datac <= '0;
               // Natural wrap brings the counter back to 0 for the next clear.
               r_cnt   <= r_cnt + 1'b1;
               if (r_cnt == LAST_ADDR) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign gnt0     = w_gnt0;
   assign gnt1     = w_gnt1;
   assign busy     = r_busy;
   assign clr_done = r_done;
   assign enc      = r_enc;
   assign addrc    = r_addrc;
   assign datac    = r_datac;

`ifdef WR_FWD_EN
   assign fwd_hit  = r_enc && (fwd_addr == r_addrc);
   assign fwd_data = fwd_hit ? r_datac : '0;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - randomized self-checking bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int NREG = 1 << AW;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          req0 = 1'b0, req1 = 1'b0, clr_start = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] data0 = '0, data1 = '0;
   logic          gnt0, gnt1, busy, clr_done, enc;
   logic [AW-1:0] addrc;
   logic [DW-1:0] datac;
`ifdef WR_FWD_EN
   logic [AW-1:0] fwd_addr = '0;
   logic          fwd_hit;
   logic [DW-1:0] fwd_data;
   int            fwd_force = -1;
   logic          last_fh;
   logic [DW-1:0] last_fd;
`endif

   regfile_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clock(clock), .reset(reset),
      .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
      .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1),
      .clr_start(clr_start), .busy(busy), .clr_done(clr_done),
      .enc(enc), .addrc(addrc), .datac(datac)
`ifdef WR_FWD_EN
      , .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: which requester wins a tie, how far a clear has got,
   // and what the write port should currently show.
   int            m_pref;
   bit            m_clear;
   int            m_idx;
   bit            m_enc;
   logic [AW-1:0] m_addrc;
   logic [DW-1:0] m_datac;
   bit            m_done;
   logic          last_g0, last_g1;
   int            done_seen = 0;

   task automatic model_reset();
      m_pref  = 0;
      m_clear = 0;
      m_idx   = 0;
      m_enc   = 0;
      m_addrc = '0;
      m_datac = '0;
      m_done  = 0;
   endtask

   // Entered at posedge+1; drives inputs, checks grants just before the edge,
   // then checks the registered outputs just after it.
   task automatic step(input bit r0, input bit r1, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1, input bit clr);
      bit e0, e1;
      req0 = r0; req1 = r1; addr0 = a0; addr1 = a1; data0 = d0; data1 = d1; clr_start = clr;
`ifdef WR_FWD_EN
      if (fwd_force >= 0) fwd_addr = AW'(fwd_force);
      else fwd_addr = ($urandom_range(0, 1) == 1) ? m_addrc : AW'($urandom);
`endif
      #7;
      e0 = 0; e1 = 0;
      if (!m_clear && !clr) begin
         if (r0 && r1) begin
            if (m_pref == 0) e0 = 1; else e1 = 1;
         end else begin
            e0 = r0; e1 = r1;
         end
      end
      check_val("gnt0", gnt0, e0);
      check_val("gnt1", gnt1, e1);
      last_g0 = gnt0; last_g1 = gnt1;
`ifdef WR_FWD_EN
      check_val("fwd_hit", fwd_hit, (m_enc && fwd_addr == m_addrc));
      check_val("fwd_data", fwd_data, (m_enc && fwd_addr == m_addrc) ? m_datac : '0);
      last_fh = fwd_hit; last_fd = fwd_data;
`endif
      m_done = 0;
      if (m_clear) begin
         m_enc = 1; m_addrc = AW'(m_idx); m_datac = '0;
         m_idx++;
         if (m_idx == NREG) begin m_clear = 0; m_idx = 0; m_done = 1; end
      end else if (clr) begin
         m_clear = 1; m_idx = 0; m_enc = 0;
      end else if (e0) begin
         m_enc = 1; m_addrc = a0; m_datac = d0; m_pref = 1;
      end else if (e1) begin
         m_enc = 1; m_addrc = a1; m_datac = d1; m_pref = 0;
      end else begin
         m_enc = 0;
      end
      @(posedge clock); #1;
      check_val("enc", enc, m_enc);
      check_val("addrc", addrc, m_addrc);
      check_val("datac", datac, m_datac);
      check_val("busy", busy, m_clear);
      check_val("clr_done", clr_done, m_done);
      if (clr_done === 1'b1) done_seen++;
   endtask

   task automatic reset_mid();
      req0 = 1; req1 = 1; clr_start = 0;
      #3;
      reset = 1;
      #1;
      check_val("rst_enc", enc, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", clr_done, 0);
      check_val("rst_gnt0", gnt0, 0);
      check_val("rst_gnt1", gnt1, 0);
      check_val("rst_addrc", addrc, 0);
      check_val("rst_datac", datac, 0);
      model_reset();
      @(posedge clock); #3;
      req0 = 0; req1 = 0;
      reset = 0;
      @(posedge clock); #1;
      check_val("post_rst_enc", enc, 0);
   endtask

   int busy_cnt, done_cnt, guard, done_before;

   initial begin
      model_reset();
      req0 = 1; req1 = 1;
      #2;
      check_val("init_enc", enc, 0);
      check_val("init_busy", busy, 0);
      check_val("init_done", clr_done, 0);
      check_val("init_gnt0", gnt0, 0);
      check_val("init_gnt1", gnt1, 0);
      check_val("init_addrc", addrc, 0);
      check_val("init_datac", datac, 0);
      req0 = 0; req1 = 0;
      @(posedge clock); #1;
      reset = 0;

      // Both requesters held: strict alternation starting with requester 0.
      for (int i = 0; i < 4; i++) begin
         step(1, 1, 5'd10, 5'd20, 32'hA0 + i, 32'hB0 + i, 0);
         check_val("rr_g0", last_g0, (i % 2 == 0));
         check_val("rr_addr", addrc, (i % 2 == 0) ? 10 : 20);
      end

      // Single write, one-cycle latency, then enc drops.
      step(1, 0, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0, 0);
      check_val("single_g0", last_g0, 1);
      check_val("single_enc", enc, 1);
      check_val("single_addr", addrc, 3);
      check_val("single_data", datac, 32'hDEADBEEF);
      step(0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 0);
      check_val("single_enc_off", enc, 0);

      // Full clear with req1 held throughout.
      done_seen = 0;
      step(0, 1, 5'd9, 5'd17, 32'h1, 32'h2, 1);
      busy_cnt = (busy === 1'b1) ? 1 : 0;
      guard = 0;
      while (busy === 1'b1 && guard < 40) begin
         step(0, 1, 5'd9, 5'd17, 32'h1, 32'h2, 0);
         if (busy === 1'b1) busy_cnt++;
         guard++;
      end
      check_val("clr_busy_cycles", busy_cnt, NREG);
      check_val("clr_done_pulses", done_seen, 1);
      step(0, 1, 5'd9, 5'd17, 32'h1, 32'h2, 0);
      check_val("clr_then_gnt1", last_g1, 1);

      // Reset in the middle of a clear.
      done_before = done_seen;
      step(0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 1);
      for (int i = 0; i < 10; i++) step(1, 0, 5'd1, 5'd2, 32'h3, 32'h4, 0);
      check_val("abort_cnt_addr", addrc, 9);
      reset_mid();
      for (int i = 0; i < 4; i++) step(0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 0);
      check_val("abort_no_done", done_seen, done_before);
      step(1, 1, 5'd4, 5'd6, 32'h44, 32'h66, 0);
      check_val("abort_resume_g0", last_g0, 1);

`ifdef WR_FWD_EN
      step(1, 0, 5'd7, 5'd0, 32'h55, 32'h0, 0);
      fwd_force = 7;
      step(0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 0);
      check_val("fwd7_hit", last_fh, 1);
      check_val("fwd7_data", last_fd, 32'h55);
      step(1, 0, 5'd7, 5'd0, 32'h55, 32'h0, 0);
      fwd_force = 8;
      step(0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 0);
      check_val("fwd8_hit", last_fh, 0);
      check_val("fwd8_data", last_fd, 0);
      fwd_force = -1;
`endif

      // Randomized traffic with occasional clears.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom), AW'($urandom),
              $urandom, $urandom, ($urandom_range(0, 39) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
